// File: rtl/tmds_encoder_dc.sv
// NCHAN-channel DVI TMDS encoder: 2-stage pipeline, transition minimisation + running-disparity DC balance.
// Define TMDS_TERC4_EN to add HDMI TERC4 data-island encoding; otherwise island/aux are ignored.
module tmds_encoder_dc #(
    parameter int unsigned NCHAN = 3,
    parameter int unsigned CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  de,
    input  logic                  island,
    input  logic [8*NCHAN-1:0]    data,
    input  logic [2*NCHAN-1:0]    ctrl,
    input  logic [4*NCHAN-1:0]    aux,
    output logic [10*NCHAN-1:0]   q,
    output logic                  de_q
);

    typedef enum logic [1:0] {MODE_CTRL, MODE_VIDEO, MODE_ISLAND} mode_t;

    localparam logic [9:0]              TOKEN_00  = 10'b1101010100;
    localparam logic signed [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic signed [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] CNT_EIGHT = CNT_W'(8);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) s = s + 4'(v[i]);
        return s;
    endfunction

    function automatic logic [8:0] min_transition(input logic [7:0] d);
        logic [8:0] m;
        logic [3:0] n1d;
        logic       use_xnor;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        m[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++)
            m[i] = use_xnor ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
        m[8] = ~use_xnor;
        return m;
    endfunction

    function automatic logic [9:0] control_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] a);
        case (a)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction
`endif

    // ---------------- Stage 1: transition minimisation ----------------
    mode_t              r_mode;
    logic [8:0]         r_qm [NCHAN];
    logic [3:0]         r_n1 [NCHAN];
    logic [2*NCHAN-1:0] r_ctrl;
    mode_t              w_mode;
    logic [8:0]         w_qm [NCHAN];
`ifdef TMDS_TERC4_EN
    logic [4*NCHAN-1:0] r_aux;
`else
    logic               w_unused;
    assign w_unused = ^{island, aux};
`endif

    always_comb begin
`ifdef TMDS_TERC4_EN
        if (de)          w_mode = MODE_VIDEO;
        else if (island) w_mode = MODE_ISLAND;
        else             w_mode = MODE_CTRL;
`else
        w_mode = de ? MODE_VIDEO : MODE_CTRL;
`endif
        for (int unsigned n = 0; n < NCHAN; n++)
            w_qm[n] = min_transition(data[8*n +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_CTRL;
            r_ctrl <= '0;
`ifdef TMDS_TERC4_EN
            r_aux  <= '0;
`endif
            for (int unsigned n = 0; n < NCHAN; n++) begin
                r_qm[n] <= '0;
                r_n1[n] <= '0;
            end
        end else begin
            r_mode <= w_mode;
            r_ctrl <= ctrl;
`ifdef TMDS_TERC4_EN
            r_aux  <= aux;
`endif
            for (int unsigned n = 0; n < NCHAN; n++) begin
                r_qm[n] <= w_qm[n];
                r_n1[n] <= popcount8(w_qm[n][7:0]);
            end
        end
    end

    // ---------------- Stage 2: DC balance / token insertion ----------------
    logic [9:0]              r_q       [NCHAN];
    logic signed [CNT_W-1:0] r_cnt     [NCHAN];
    logic                    r_de_q;
    logic [9:0]              w_q_nxt   [NCHAN];
    logic signed [CNT_W-1:0] w_cnt_nxt [NCHAN];
    logic signed [CNT_W-1:0] w_bal     [NCHAN];
    logic                    w_inv     [NCHAN];

    always_comb begin
        for (int unsigned n = 0; n < NCHAN; n++) begin
            // w_bal = N1 - N0 = 2*N1 - 8
            w_bal[n]     = $signed(CNT_W'({r_n1[n], 1'b0})) - CNT_EIGHT;
            w_inv[n]     = 1'b0;
            w_cnt_nxt[n] = CNT_ZERO;
            w_q_nxt[n]   = control_token(r_ctrl[2*n +: 2]);
            if (r_mode == MODE_VIDEO) begin
                if (r_cnt[n] == CNT_ZERO || w_bal[n] == CNT_ZERO) begin
                    w_inv[n]     = ~r_qm[n][8];
                    w_cnt_nxt[n] = r_qm[n][8] ? (r_cnt[n] + w_bal[n]) : (r_cnt[n] - w_bal[n]);
                end else if (r_cnt[n][CNT_W-1] == w_bal[n][CNT_W-1]) begin
                    w_inv[n]     = 1'b1;
                    w_cnt_nxt[n] = r_cnt[n] - w_bal[n] + (r_qm[n][8] ? CNT_TWO : CNT_ZERO);
                end else begin
                    w_inv[n]     = 1'b0;
                    w_cnt_nxt[n] = r_cnt[n] + w_bal[n] - (r_qm[n][8] ? CNT_ZERO : CNT_TWO);
                end
                w_q_nxt[n] = {w_inv[n], r_qm[n][8], w_inv[n] ? ~r_qm[n][7:0] : r_qm[n][7:0]};
            end
`ifdef TMDS_TERC4_EN
            else if (r_mode == MODE_ISLAND) begin
                w_q_nxt[n] = terc4(r_aux[4*n +: 4]);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_q <= 1'b0;
            for (int unsigned n = 0; n < NCHAN; n++) begin
                r_q[n]   <= TOKEN_00;
                r_cnt[n] <= CNT_ZERO;
            end
        end else begin
            r_de_q <= (r_mode == MODE_VIDEO);
            for (int unsigned n = 0; n < NCHAN; n++) begin
                r_q[n]   <= w_q_nxt[n];
                r_cnt[n] <= w_cnt_nxt[n];
            end
        end
    end

    always_comb begin
        q = '0;
        for (int unsigned n = 0; n < NCHAN; n++)
            q[10*n +: 10] = r_q[n];
    end

    assign de_q = r_de_q;

endmodule

// File: tb/tb_tmds_encoder_dc.sv
// Scoreboard bench for tmds_encoder_dc: directed corner cases plus random pixels vs. a disparity-based model.
// Honours TMDS_TERC4_EN the same way as the design.
module tb_tmds_encoder_dc;
    localparam int NCHAN = 3;
    localparam logic [9:0] TOK00 = 10'b1101010100;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 de = 1'b0;
    logic                 island = 1'b0;
    logic [8*NCHAN-1:0]   data = '0;
    logic [2*NCHAN-1:0]   ctrl = '0;
    logic [4*NCHAN-1:0]   aux = '0;
    logic [10*NCHAN-1:0]  q;
    logic                 de_q;

    tmds_encoder_dc #(.NCHAN(NCHAN), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .de(de), .island(island),
        .data(data), .ctrl(ctrl), .aux(aux), .q(q), .de_q(de_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10*NCHAN-1:0] q;
        logic                de;
        string               name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mcnt[NCHAN];

    function automatic int ones(input logic [9:0] v);
        int s = 0;
        for (int i = 0; i < 10; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic logic [9:0] token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] a);
        logic [9:0] t [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                               10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                               10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                               10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        return t[a];
    endfunction
`endif

    // Disparity model: inversion chosen from the running balance, then cnt tracks ones-minus-zeros of each sent symbol.
    function automatic logic [9:0] model_sym(input int ch, input logic v_de, input logic v_isl,
                                             input logic [7:0] d, input logic [1:0] c, input logic [3:0] a);
        int         n1d, bal;
        logic       use_xnor, inv;
        logic [7:0] qm;
        logic [9:0] sym;
        if (!v_de) begin
            mcnt[ch] = 0;
`ifdef TMDS_TERC4_EN
            if (v_isl) return terc4(a);
`endif
            return token(c);
        end
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        bal = 2 * ones({2'b00, qm}) - 8;
        if (mcnt[ch] == 0 || bal == 0) inv = use_xnor;
        else                           inv = ((mcnt[ch] > 0) == (bal > 0));
        sym = {inv, !use_xnor, inv ? ~qm : qm};
        mcnt[ch] += 2 * ones(sym) - 10;
        return sym;
    endfunction

    // Drives one pixel (blocking), pushes the expected symbol, then advances to the next negedge.
    task automatic drive(input logic v_de, input logic v_isl, input logic [8*NCHAN-1:0] v_d,
                         input logic [2*NCHAN-1:0] v_c, input logic [4*NCHAN-1:0] v_a,
                         input string nm, input bit fix, input logic [9:0] fix_sym);
        exp_t       e;
        logic [9:0] s;
        de = v_de; island = v_isl; data = v_d; ctrl = v_c; aux = v_a;
        for (int ch = 0; ch < NCHAN; ch++) begin
            s = model_sym(ch, v_de, v_isl, v_d[8*ch +: 8], v_c[2*ch +: 2], v_a[4*ch +: 4]);
            e.q[10*ch +: 10] = fix ? fix_sym : s;
        end
        e.de = v_de;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic push_post_reset();
        exp_t e;
        e.q = {NCHAN{TOK00}};
        e.de = 1'b0;
        e.name = "post_reset";
        sb.push_back(e);
        for (int ch = 0; ch < NCHAN; ch++) mcnt[ch] = 0;
    endtask

    task automatic check_reset_state(input string nm);
        checks++;
        if (q !== {NCHAN{TOK00}} || de_q !== 1'b0) begin
            failures++;
            $display("FAIL %s: q=%h de_q=%b expected q=%h de_q=0", nm, q, de_q, {NCHAN{TOK00}});
        end
    endtask

    // Monitor: one output symbol per cycle, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== e.q || de_q !== e.de) begin
                    failures++;
                    $display("FAIL %s: q=%h de_q=%b expected q=%h de_q=%b", e.name, q, de_q, e.q, e.de);
                end
            end
        end
    end

    initial begin
        logic       r_de;
        logic [9:0] exp_terc;
        for (int ch = 0; ch < NCHAN; ch++) mcnt[ch] = 0;

        repeat (3) @(negedge clk);
        check_reset_state("reset_hold");
        rst_n = 1'b1;
        push_post_reset();
        drive(0, 0, '0, '0, '0, "idle_ctrl00", 1, TOK00);

        drive(1, 0, {NCHAN{8'h00}}, '0, '0, "dc_first_00", 1, 10'h100);
        drive(1, 0, {NCHAN{8'h00}}, '0, '0, "dc_second_00", 1, 10'h3FF);
        drive(0, 0, '0, '0, '0, "blank", 1, TOK00);
        drive(1, 0, {NCHAN{8'hFF}}, '0, '0, "xnor_ff", 1, 10'h200);
        drive(1, 0, {NCHAN{8'h55}}, '0, '0, "xor_55_balanced", 1, 10'h133);

        drive(0, 0, '0, {NCHAN{2'b00}}, '0, "ctrl_00", 1, 10'b1101010100);
        drive(0, 0, '0, {NCHAN{2'b01}}, '0, "ctrl_01", 1, 10'b0010101011);
        drive(0, 0, '0, {NCHAN{2'b10}}, '0, "ctrl_10", 1, 10'b0101010100);
        drive(0, 0, '0, {NCHAN{2'b11}}, '0, "ctrl_11", 1, 10'b1010101011);
        // cnt was -8 before the blanking; video must restart from zero, and de must beat island
        drive(1, 1, {NCHAN{8'h00}}, '0, '0, "cnt_clear_de_over_island", 1, 10'h100);
        drive(1, 1, {NCHAN{8'h00}}, '0, '0, "de_over_island_2nd", 1, 10'h3FF);

`ifdef TMDS_TERC4_EN
        exp_terc = 10'b1001100011;
`else
        exp_terc = 10'b0101010100;
`endif
        drive(0, 1, '0, {NCHAN{2'b10}}, {NCHAN{4'b0001}}, "island_aux1", 1, exp_terc);
        drive(0, 1, '0, {NCHAN{2'b01}}, {NCHAN{4'b1111}}, "island_aux15", 0, '0);

        drive(1, 0, 24'h12_80_F0, '0, '0, "mixed_chan_a", 0, '0);
        drive(1, 0, 24'h00_FF_3C, '0, '0, "mixed_chan_b", 0, '0);

        // Mid-line reset: pipeline contents are discarded and disparity restarts from zero.
        drive(1, 0, {NCHAN{8'h00}}, '0, '0, "pre_reset_video", 0, '0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_state("async_reset_midline");
        @(negedge clk);
        check_reset_state("reset_held");
        rst_n = 1'b1;
        push_post_reset();
        drive(1, 0, {NCHAN{8'h00}}, '0, '0, "post_reset_video", 1, 10'h100);

        r_de = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) r_de = ~r_de;
            drive(r_de, 1'($urandom_range(0, 3) == 0), (8*NCHAN)'($urandom), (2*NCHAN)'($urandom),
                  (4*NCHAN)'($urandom), "random", 0, '0);
        end
        drive(0, 0, '0, '0, '0, "tail", 0, '0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
